cpu6_mdu_seq: RTL and testbench

//  Iterative multiply/divide sequencer for RV32M, sitting beside the cpu6 EX-stage ALU/shifter.
//  The decoder asserts mdu_start for OP (0110011) with funct7=0000001. The block stalls the pipeline

---
 rtl/cpu6_mdu_pkg.sv | 43 ++++
 rtl/cpu6_mdu_dp.sv | 128 ++++++++++++
 rtl/cpu6_mdu_seq.sv | 99 +++++++++
 tb/tb_cpu6_mdu_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu6_mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu6_mdu_pkg
//  Purpose  : Shared definitions for the cpu6 RV32M multiply/divide unit:
//             sequencer state encoding, the M-extension funct7 value,
//             funct3 operation codes and small decode helpers.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package cpu6_mdu_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    // funct7 that marks an OP-class instruction as belonging to RV32M
    localparam logic [6:0] c_MDU_FUNCT7 = 7'b0000001;

    // funct3 operation codes
    localparam logic [2:0] c_MDU_OP_MUL    = 3'b000;
    localparam logic [2:0] c_MDU_OP_MULH   = 3'b001;
    localparam logic [2:0] c_MDU_OP_MULHSU = 3'b010;
    localparam logic [2:0] c_MDU_OP_MULHU  = 3'b011;
    localparam logic [2:0] c_MDU_OP_DIV    = 3'b100;
    localparam logic [2:0] c_MDU_OP_DIVU   = 3'b101;
    localparam logic [2:0] c_MDU_OP_REM    = 3'b110;
    localparam logic [2:0] c_MDU_OP_REMU   = 3'b111;

    // Divide-class operations (DIV/DIVU/REM/REMU) all have funct3[2] set
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

    // REM/REMU return the remainder rather than the quotient
    function automatic logic is_rem_op(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

endpackage : cpu6_mdu_pkg
`default_nettype wire

// File: rtl/cpu6_mdu_dp.sv
`default_nettype none
// ============================================================================
//  Module   : cpu6_mdu_dp
//  Purpose  : Datapath of the iterative multiply/divide unit. Holds operand
//             magnitudes, the accumulator and the result sign; performs one
//             shift-add (multiply) or restoring-subtract (divide) step per
//             enabled cycle and forms the final, sign-corrected result.
//  Ports    : clk, resetn        - clock, async active-low reset
//             load               - capture operands/op for a new instruction
//             step               - advance the algorithm by one bit
//             funct3, rs1, rs2   - operation and raw operands (sampled on load)
//             special            - current inputs are div-by-zero / overflow
//             result             - final result of the loaded operation
//  Revision : 1.0  initial release
// ============================================================================
module cpu6_mdu_dp
    import cpu6_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            special,
    output logic [XLEN-1:0] result
);

    // Registered operation context
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_opa;         // multiplier / dividend, becomes low product / quotient
    logic [XLEN-1:0] r_opb;         // multiplicand / divisor magnitude
    logic [XLEN-1:0] r_acc;         // high product / partial remainder
    logic            r_neg;         // final result must be negated
    logic            r_special;
    logic [XLEN-1:0] r_special_val;

    // ---------------- operand decode (used on load) ----------------
    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_res_neg, w_div_zero, w_ovf;
    logic [XLEN-1:0] w_special_val;

    assign w_a_signed = (funct3 == c_MDU_OP_MUL)    || (funct3 == c_MDU_OP_MULH) ||
                        (funct3 == c_MDU_OP_MULHSU) || (funct3 == c_MDU_OP_DIV)  ||
                        (funct3 == c_MDU_OP_REM);
    assign w_b_signed = (funct3 == c_MDU_OP_MUL) || (funct3 == c_MDU_OP_MULH) ||
                        (funct3 == c_MDU_OP_DIV) || (funct3 == c_MDU_OP_REM);
    assign w_a_neg    = w_a_signed & rs1[XLEN-1];
    assign w_b_neg    = w_b_signed & rs2[XLEN-1];
    // -(0x8000_0000) wraps to itself, which is the correct unsigned magnitude
    assign w_a_mag    = w_a_neg ? (~rs1 + 1'b1) : rs1;
    assign w_b_mag    = w_b_neg ? (~rs2 + 1'b1) : rs2;
    // Remainder follows the dividend; product and quotient follow the sign XOR
    assign w_res_neg  = is_rem_op(funct3) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div_zero = is_div_op(funct3) && (rs2 == '0);
    assign w_ovf      = ((funct3 == c_MDU_OP_DIV) || (funct3 == c_MDU_OP_REM)) &&
                        (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    assign special    = w_div_zero | w_ovf;

    always_comb begin
        w_special_val = '0;
        if (w_div_zero) begin
            w_special_val = is_rem_op(funct3) ? rs1 : '1;
        end else if (w_ovf) begin
            w_special_val = is_rem_op(funct3) ? '0 : rs1;
        end
    end

    // ---------------- iteration step ----------------
    logic [XLEN:0]   w_add;     // shift-add partial sum with carry
    logic [XLEN:0]   w_shift;   // remainder shifted left with next dividend bit
    logic [XLEN:0]   w_diff;
    logic            w_ge;

    assign w_add   = {1'b0, r_acc} + (r_opa[0] ? {1'b0, r_opb} : '0);
    assign w_shift = {r_acc, r_opa[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_opb};
    assign w_ge    = ~w_diff[XLEN];     // no borrow: divisor fits, quotient bit is 1

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op          <= '0;
            r_opa         <= '0;
            r_opb         <= '0;
            r_acc         <= '0;
            r_neg         <= 1'b0;
            r_special     <= 1'b0;
            r_special_val <= '0;
        end else if (load) begin
            r_op          <= funct3;
            r_opa         <= w_a_mag;
            r_opb         <= w_b_mag;
            r_acc         <= '0;
            r_neg         <= w_res_neg;
            r_special     <= special;
            r_special_val <= w_special_val;
        end else if (step) begin
            if (is_div_op(r_op)) begin
                r_acc <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                r_opa <= {r_opa[XLEN-2:0], w_ge};
            end else begin
                // {acc, opa} shifts right as one 2*XLEN register
                r_acc <= w_add[XLEN:1];
                r_opa <= {w_add[0], r_opa[XLEN-1:1]};
            end
        end
    end

    // ---------------- final sign correction ----------------
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_quot_s, w_rem_s, w_mul_res, w_div_res;

    assign w_prod    = {r_acc, r_opa};
    assign w_prod_s  = r_neg ? (~w_prod + 1'b1) : w_prod;
    assign w_quot_s  = r_neg ? (~r_opa + 1'b1) : r_opa;
    assign w_rem_s   = r_neg ? (~r_acc + 1'b1) : r_acc;
    assign w_mul_res = (r_op == c_MDU_OP_MUL) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
    assign w_div_res = is_rem_op(r_op) ? w_rem_s : w_quot_s;
    assign result    = r_special ? r_special_val :
                       (is_div_op(r_op) ? w_div_res : w_mul_res);

endmodule : cpu6_mdu_dp
`default_nettype wire

// File: rtl/cpu6_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cpu6_mdu_seq
//  Purpose  : Iterative RV32M multiply/divide sequencer beside the cpu6 EX
//             stage. Stalls the pipeline for 32 steps, then presents the
//             result for one cycle. Division special cases finish at once.
//  Ports    : clk, resetn             - clock, async active-low reset
//             mdu_start               - EX holds a valid M instruction
//             mdu_funct3              - operation select
//             mdu_rs1, mdu_rs2        - operands
//             mdu_kill                - flush, abort any operation
//             mdu_stall               - hold IF/ID/EX
//             mdu_busy                - operation in flight
//             mdu_result_valid        - one-cycle result strobe
//             mdu_result              - rd write data
//  Revision : 1.0  initial release
// ============================================================================
module cpu6_mdu_seq
    import cpu6_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            mdu_start,
    input  logic [2:0]      mdu_funct3,
    input  logic [XLEN-1:0] mdu_rs1,
    input  logic [XLEN-1:0] mdu_rs2,
    input  logic            mdu_kill,
    output logic            mdu_stall,
    output logic            mdu_busy,
    output logic            mdu_result_valid,
    output logic [XLEN-1:0] mdu_result
);

    mdu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_result;     // last delivered result, held between operations

    logic             w_accept, w_step, w_special;
    logic [XLEN-1:0]  w_final;

    assign w_accept = (r_state == MDU_IDLE) & mdu_start & ~mdu_kill;
    assign w_step   = (r_state == MDU_CALC) & ~mdu_kill;

    cpu6_mdu_dp #(
        .XLEN    (XLEN)
    ) u_dp (
        .clk     (clk),
        .resetn  (resetn),
        .load    (w_accept),
        .step    (w_step),
        .funct3  (mdu_funct3),
        .rs1     (mdu_rs1),
        .rs2     (mdu_rs2),
        .special (w_special),
        .result  (w_final)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= MDU_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (mdu_kill) begin
            r_state <= MDU_IDLE;
        end else begin
            case (r_state)
                MDU_IDLE: begin
                    if (mdu_start) begin
                        r_cnt   <= '0;
                        r_state <= w_special ? MDU_DONE : MDU_CALC;
                    end
                end
                MDU_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(XLEN-1)) begin
                        r_state <= MDU_DONE;
                    end
                end
                MDU_DONE: begin
                    r_result <= w_final;
                    r_state  <= MDU_IDLE;
                end
                default: r_state <= MDU_IDLE;
            endcase
        end
    end

    // Stall is gated with resetn so the core sees all-zero outputs during reset
    // even if the decoder still presents an instruction.
    assign mdu_stall        = resetn & (w_accept | (r_state == MDU_CALC));
    assign mdu_busy         = (r_state != MDU_IDLE);
    assign mdu_result_valid = (r_state == MDU_DONE) & ~mdu_kill;
    assign mdu_result       = (r_state == MDU_DONE) ? w_final : r_result;

endmodule : cpu6_mdu_seq
`default_nettype wire

// File: tb/tb_cpu6_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu6_mdu_seq
//  Purpose  : Self-checking bench for cpu6_mdu_seq. A reference model built
//             from RV32M arithmetic predicts stall/busy/valid/result every
//             cycle; directed vectors carry hand-computed literal results.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu6_mdu_seq;

    logic        clk;
    logic        resetn;
    logic        mdu_start;
    logic [2:0]  mdu_funct3;
    logic [31:0] mdu_rs1;
    logic [31:0] mdu_rs2;
    logic        mdu_kill;
    logic        mdu_stall;
    logic        mdu_busy;
    logic        mdu_result_valid;
    logic [31:0] mdu_result;

    int n_cmp  = 0;
    int n_fail = 0;

    cpu6_mdu_seq #(
        .XLEN  (32),
        .CNT_W (5)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .mdu_start        (mdu_start),
        .mdu_funct3       (mdu_funct3),
        .mdu_rs1          (mdu_rs1),
        .mdu_rs2          (mdu_rs2),
        .mdu_kill         (mdu_kill),
        .mdu_stall        (mdu_stall),
        .mdu_busy         (mdu_busy),
        .mdu_result_valid (mdu_result_valid),
        .mdu_result       (mdu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ua, p;
        logic [63:0] pu;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ia = $signed(a);
        ib = $signed(b);
        pu = {32'd0, a} * {32'd0, b};
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: return pu[63:32];
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
        if (ua < 0) return 32'd0;   // unreachable; keeps every path returning
    endfunction

    function automatic logic is_special(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
        return f[2] && ((b == 32'd0) ||
               (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // ---------------- cycle-level expectation ----------------
    // m_cnt counts cycles since acceptance; the result cycle is m_done.
    logic        m_active;
    int          m_cnt, m_done;
    logic [31:0] m_exp, m_last;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
            m_done   <= 0;
            m_exp    <= 32'd0;
            m_last   <= 32'd0;
        end else if (mdu_kill) begin
            m_active <= 1'b0;
        end else if (!m_active) begin
            if (mdu_start) begin
                m_active <= 1'b1;
                m_cnt    <= 1;
                m_done   <= is_special(mdu_funct3, mdu_rs1, mdu_rs2) ? 1 : 33;
                m_exp    <= ref_mdu(mdu_funct3, mdu_rs1, mdu_rs2);
            end
        end else if (m_cnt == m_done) begin
            m_active <= 1'b0;
            m_last   <= m_exp;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    logic e_done, e_valid, e_stall;
    always @(negedge clk) begin
        e_done  = m_active && (m_cnt == m_done);
        e_valid = resetn && e_done && !mdu_kill;
        e_stall = resetn && ((!m_active && mdu_start && !mdu_kill) ||
                             (m_active && m_cnt < m_done));
        check("stall", {31'd0, mdu_stall}, {31'd0, e_stall});
        check("busy", {31'd0, mdu_busy}, {31'd0, m_active});
        check("valid", {31'd0, mdu_result_valid}, {31'd0, e_valid});
        if (e_valid)
            check("result", mdu_result, m_exp);
        else if (!e_done)
            check("held_result", mdu_result, m_last);
    end

    // ---------------- directed operations ----------------
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int          cyc;
        int          nstall;
        logic        got;
        logic [31:0] res;
        check({name, " model"}, ref_mdu(f, a, b), exp);
        @(posedge clk); #1;
        mdu_start  = 1'b1;
        mdu_funct3 = f;
        mdu_rs1    = a;
        mdu_rs2    = b;
        cyc = 0; nstall = 0; got = 1'b0; res = 32'd0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (mdu_stall) nstall++;
            if (mdu_result_valid) begin
                got       = 1'b1;
                res       = mdu_result;
                mdu_start = 1'b0;
            end else begin
                cyc++;
            end
        end
        if (!got) begin
            mdu_start = 1'b0;
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: no result_valid within 40 cycles, required cycle %0d", name, lat);
        end else begin
            check({name, " result"}, res, exp);
            check({name, " latency"}, cyc, lat);
            check({name, " stall_cycles"}, nstall, lat);
        end
    endtask

    initial begin
        int seen;
        resetn     = 1'b0;
        mdu_start  = 1'b0;
        mdu_funct3 = 3'd0;
        mdu_rs1    = 32'd0;
        mdu_rs2    = 32'd0;
        mdu_kill   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, mdu_busy}, 32'd0);
        check("reset valid", {31'd0, mdu_result_valid}, 32'd0);
        check("reset result", mdu_result, 32'd0);
        resetn = 1'b1;

        run_op("MUL 7*-3",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("MULH min*min",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        run_op("MULHU min*min",   3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        run_op("MULHSU min*min",  3'd2, 32'h8000_0000,  32'h8000_0000, 32'hC000_0000, 33);
        run_op("MULHU -1*-1",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("MULH -1*-1",      3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("DIV -7/2",        3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run_op("REM -7/2",        3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("DIV 7/-2",        3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("REM 7/-2",        3'd6, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 33);
        run_op("DIVU 100/7",      3'd5, 32'd100,        32'd7,         32'd14,        33);
        run_op("REMU 100/7",      3'd7, 32'd100,        32'd7,         32'd2,         33);
        run_op("DIVU max/1",      3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33);
        run_op("DIVU x/0",        3'd5, 32'd1234,       32'd0,         32'hFFFF_FFFF, 1);
        run_op("REMU 5/0",        3'd7, 32'd5,          32'd0,         32'd5,         1);
        run_op("REM ovf",         3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
        run_op("DIV ovf",         3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);

        // Kill in cycle 10 of a DIV
        @(posedge clk); #1;
        mdu_start = 1'b1; mdu_funct3 = 3'd4; mdu_rs1 = 32'd1000; mdu_rs2 = 32'd9;
        repeat (10) @(posedge clk);
        #1 mdu_kill = 1'b1;
        @(posedge clk); #1;
        mdu_kill = 1'b0; mdu_start = 1'b0;
        @(negedge clk);
        check("kill busy cycle 11", {31'd0, mdu_busy}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (mdu_result_valid) seen++;
        end
        check("kill no result", seen, 32'd0);

        // Start together with kill is not accepted
        @(posedge clk); #1;
        mdu_start = 1'b1; mdu_kill = 1'b1; mdu_funct3 = 3'd0; mdu_rs1 = 32'd3; mdu_rs2 = 32'd3;
        @(negedge clk);
        check("start+kill stall", {31'd0, mdu_stall}, 32'd0);
        @(posedge clk); #1;
        mdu_start = 1'b0; mdu_kill = 1'b0;
        @(negedge clk);
        check("start+kill busy", {31'd0, mdu_busy}, 32'd0);

        // Reset in cycle 5 of a MUL
        @(posedge clk); #1;
        mdu_start = 1'b1; mdu_funct3 = 3'd0; mdu_rs1 = 32'd5; mdu_rs2 = 32'd6;
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0; mdu_start = 1'b0;
        #1;
        check("rst busy", {31'd0, mdu_busy}, 32'd0);
        check("rst stall", {31'd0, mdu_stall}, 32'd0);
        check("rst valid", {31'd0, mdu_result_valid}, 32'd0);
        check("rst result", mdu_result, 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        run_op("MUL 3*4 after reset", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_cpu6_mdu_seq
`default_nettype wire
